tpu_avalon_sequencer: RTL and testbench
=======================================

// Module: tpu_avalon_sequencer
// PURPOSE
//  Avalon-MM slave between the HPS/Qsys fabric and the TPU top. Packs BUS_WIDTH beats into full
//  TPU rows for input/weight memories, unpacks output rows, and runs a hardware sequencer
//  (reset pulse, fill, drain, multiply, or full auto RUN) with status, sticky flags, watchdog, irq.
// PARAMETERS
//  BUS_WIDTH       64   Avalon data width; TPU_W % BUS_WIDTH == 0, BEATS = TPU_W/BUS_WIDTH, power of 2
//  WIDTH_HEIGHT    16   systolic array dimension; TPU_W = WIDTH_HEIGHT*8
//  MEM_ADDR_WIDTH  8    TPU memory row address width
//  RESET_CYCLES    4    cycles tpu_reset is held per RESET command (>=1)
//  TIMEOUT_CYCLES  4096 max cycles in any FILL/DRAIN/MULT phase before abort
//  (localparams BEAT_BITS = clog2(BEATS), ADDR_WIDTH = 2 + MEM_ADDR_WIDTH + BEAT_BITS)
// PORTS
//  clk                 in  1                   clock
//  reset_n             in  1                   async active-low reset
//  slave_address       in  ADDR_WIDTH          [top2]=space, [BEAT_BITS+:MEM_ADDR_WIDTH]=row, [BEAT_BITS-1:0]=beat
//  slave_read          in  1                   read strobe
//  slave_write         in  1                   write strobe
//  slave_writedata     in  BUS_WIDTH           write data
//  slave_byteenable    in  BUS_WIDTH/8         byte lanes
//  slave_readdata      out BUS_WIDTH           registered read data
//  slave_readdatavalid out 1                   one cycle after accepted read
//  irq                 out 1                   done_sticky & irq_en
//  tpu_reset / tpu_active / fill_fifo / drain_fifo  out 1  TPU controls
//  {inputMem,weightMem}_wr_en   out WIDTH_HEIGHT   per-column row write enable (replicated)
//  {inputMem,weightMem}_wr_addr out WIDTH_HEIGHT*MEM_ADDR_WIDTH  row address, replicated
//  {inputMem,weightMem}_wr_data out TPU_W      packed row
//  {input,weight,output}Mem_*_addr_base out WIDTH_HEIGHT*MEM_ADDR_WIDTH  replicated bases
//  outputMem_rd_en     out WIDTH_HEIGHT        read enable;  outputMem_rd_addr out WIDTH_HEIGHT*MEM_ADDR_WIDTH
//  outputMem_rd_data   in  TPU_W               valid 1 cycle after rd_en
//  mem_to_fifo_done / fifo_to_arr_done / output_done  in 1  TPU phase-done levels
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, row buffers 0, flags/irq_en/bases 0. No waitrequest; 1 op/cycle.
//  Spaces: 00 ctrl, 01 input mem, 10 weight mem, 11 output mem.
//  Mem write: byte-enabled merge of beat b into row buffer (per space) at [b*BUS_WIDTH+:BUS_WIDTH];
//   unenabled bytes keep prior contents. Write to beat BEATS-1 issues the row write next cycle
//   (wr_en 1 cycle, addr = row, data = merged buffer). Buffer not cleared after commit.
//  Mem write while state in FILL/DRAIN/MULT: dropped, err_sticky set.
//  Output read: rd_en same cycle as read; readdata = rd_data beat slice, readdatavalid next cycle
//   (beat index pipelined). Ctrl/other reads: readdata next cycle, readdatavalid too.
//  Ctrl rows: 0 CMD (W), 1 IRQ_EN bit0 (R/W), 2 STATUS (R; W1C bits 4,5,6).
//   STATUS = {..., output_done[10], fifo_to_arr_done[9], mem_to_fifo_done[8],
//             timeout[6], err[5], done[4], state[3:1], busy[0]}.
//  CMD [3:0]: F RESET, 1 FILL(w_base=[11:4]), 2 DRAIN, 3 MULT(in=[11:4],out=[19:12]),
//   4 RUN(w=[11:4],in=[19:12],out=[27:20]). Bases latched on accepted command.
//  FSM: IDLE=0, RST=1, FILL=2, DRAIN=3, MULT=4. busy = state!=IDLE.
//   IDLE: cmd 1/2/3 -> that phase; 4 -> FILL with run flag; F -> RST.
//   RST: tpu_reset=1 for RESET_CYCLES, all else 0 -> IDLE (run flag cleared, no done).
//   FILL: fill_fifo=1 until mem_to_fifo_done -> DRAIN if run else IDLE+done.
//   DRAIN: drain_fifo=1 until fifo_to_arr_done -> MULT if run else IDLE+done.
//   MULT: tpu_active=1 until output_done -> IDLE+done.
//   Exactly one phase control high at a time; done input sampled same cycle exits next cycle.
//  RESET command accepted in any state (aborts phase, no err). Other cmd while busy: ignored, err set.
//  Unknown opcode: ignored, err set. Watchdog counter cleared on phase entry; reaching
//   TIMEOUT_CYCLES -> IDLE, timeout+err set, no done. W1C and set same cycle: set wins.
//  reset_n assertion mid-phase: immediate async return to reset values.
// TESTING
//  1 RESET cmd -> tpu_reset high exactly 4 cycles, state 1 then 0, done=0.
//  2 Write input row 5 beats 0,1 (BE=FF) 0x11..,0x22.. -> one wr_en pulse, addr 5, data {0x22..,0x11..}.
//  3 Beat0 BE=0x0F after full row -> only low 4 bytes change on next commit.
//  4 RUN w=2,in=3,out=7; done inputs at +10/+20/+30 -> FILL->DRAIN->MULT->IDLE, done, irq if en.
//  5 FILL, hold mem_to_fifo_done=0 -> exit after 4096 cycles, STATUS timeout=1 err=1; W1C 0x60 clears.
//  6 MULT busy + cmd 2 -> err=1, state stays 4; output read row 7 beat 1 -> rd_data[127:64], valid +1.

Source files
------------

// File: rtl/tpu_avalon_sequencer_if.sv
// Avalon-MM slave bundle between the HPS/Qsys fabric and the TPU sequencer.
// Handshake: no waitrequest, so every read/write strobe is accepted in the cycle it is seen;
// each accepted read returns exactly one readdatavalid cycle, one clock later.
interface tpu_avalon_sequencer_if #(
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0]  slave_address;
  logic                   slave_read;
  logic                   slave_write;
  logic [BUS_WIDTH-1:0]   slave_writedata;
  logic [BUS_WIDTH/8-1:0] slave_byteenable;
  logic [BUS_WIDTH-1:0]   slave_readdata;
  logic                   slave_readdatavalid;

  modport master (
    output slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
    input  slave_readdata, slave_readdatavalid
  );

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
    output slave_readdata, slave_readdatavalid
  );
endinterface

// File: rtl/tpu_avalon_sequencer.sv
// Avalon-MM slave for the TPU: packs bus beats into memory rows, unpacks output rows and
// runs the reset/fill/drain/multiply sequencer with sticky status, watchdog and irq.
module tpu_avalon_sequencer #(
  parameter int BUS_WIDTH      = 64,
  parameter int WIDTH_HEIGHT   = 16,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int TPU_W         = WIDTH_HEIGHT * 8,
  localparam int BEATS         = TPU_W / BUS_WIDTH,
  localparam int BEAT_BITS     = $clog2(BEATS),
  localparam int ADDR_WIDTH    = 2 + MEM_ADDR_WIDTH + BEAT_BITS,
  localparam int REP_W         = WIDTH_HEIGHT * MEM_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  tpu_avalon_sequencer_if.slave   bus,
  output logic                    irq,
  output logic                    tpu_reset,
  output logic                    tpu_active,
  output logic                    fill_fifo,
  output logic                    drain_fifo,
  output logic [WIDTH_HEIGHT-1:0] inputMem_wr_en,
  output logic [REP_W-1:0]        inputMem_wr_addr,
  output logic [TPU_W-1:0]        inputMem_wr_data,
  output logic [WIDTH_HEIGHT-1:0] weightMem_wr_en,
  output logic [REP_W-1:0]        weightMem_wr_addr,
  output logic [TPU_W-1:0]        weightMem_wr_data,
  output logic [REP_W-1:0]        inputMem_rd_addr_base,
  output logic [REP_W-1:0]        weightMem_rd_addr_base,
  output logic [REP_W-1:0]        outputMem_wr_addr_base,
  output logic [WIDTH_HEIGHT-1:0] outputMem_rd_en,
  output logic [REP_W-1:0]        outputMem_rd_addr,
  input  logic [TPU_W-1:0]        outputMem_rd_data,
  input  logic                    mem_to_fifo_done,
  input  logic                    fifo_to_arr_done,
  input  logic                    output_done,
  output logic [2:0]              dbg_state
);

  localparam int BEAT_IDX_W = (BEAT_BITS > 0) ? BEAT_BITS : 1;
  localparam int CNT_MAX    = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] SP_CTRL = 2'd0;
  localparam logic [1:0] SP_IN   = 2'd1;
  localparam logic [1:0] SP_W    = 2'd2;
  localparam logic [1:0] SP_OUT  = 2'd3;

  localparam logic [3:0] OP_FILL  = 4'h1;
  localparam logic [3:0] OP_DRAIN = 4'h2;
  localparam logic [3:0] OP_MULT  = 4'h3;
  localparam logic [3:0] OP_RUN   = 4'h4;
  localparam logic [3:0] OP_RESET = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_FILL  = 3'd2,
    S_DRAIN = 3'd3,
    S_MULT  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   run_q, run_d;
  logic   [CNT_W-1:0] cnt_q;
  logic   cnt_restart, cmd_go;
  logic   set_done, set_err, set_timeout;
  logic   done_q, err_q, timeout_q, irq_en_q;
  logic   [MEM_ADDR_WIDTH-1:0] in_base_q, w_base_q, out_base_q;

  logic [TPU_W-1:0]          in_buf_q, w_buf_q;
  logic                      in_commit_q, w_commit_q;
  logic [MEM_ADDR_WIDTH-1:0] in_row_q, w_row_q;
  logic                      rvalid_q, out_rvalid_q;
  logic [BEAT_IDX_W-1:0]     out_beat_q;
  logic [BUS_WIDTH-1:0]      rdata_q, rd_mux;

  // Address decode
  logic [1:0]                space;
  logic [MEM_ADDR_WIDTH-1:0] row;
  logic [BEAT_IDX_W-1:0]     beat;
  logic                      last_beat, phase_busy;
  logic                      ctrl_wr, cmd_wr, in_wr_ok, w_wr_ok, mem_wr_drop, out_rd;
  logic [3:0]                opcode;
  logic [2:0]                w1c;
  logic [10:0]               status;

  assign space = bus.slave_address[ADDR_WIDTH-1 -: 2];
  assign row   = bus.slave_address[BEAT_BITS +: MEM_ADDR_WIDTH];

  if (BEAT_BITS > 0) begin : g_beat
    assign beat = bus.slave_address[BEAT_IDX_W-1:0];
  end else begin : g_single_beat
    assign beat = '0;
  end

  assign last_beat   = (beat == BEAT_IDX_W'(BEATS - 1));
  assign phase_busy  = (state_q == S_FILL) || (state_q == S_DRAIN) || (state_q == S_MULT);
  assign ctrl_wr     = bus.slave_write && (space == SP_CTRL);
  assign cmd_wr      = ctrl_wr && (row == MEM_ADDR_WIDTH'(0));
  assign opcode      = bus.slave_writedata[3:0];
  assign w1c         = (ctrl_wr && (row == MEM_ADDR_WIDTH'(2))) ? bus.slave_writedata[6:4] : 3'b000;
  assign in_wr_ok    = bus.slave_write && (space == SP_IN) && !phase_busy;
  assign w_wr_ok     = bus.slave_write && (space == SP_W) && !phase_busy;
  assign mem_wr_drop = bus.slave_write && ((space == SP_IN) || (space == SP_W)) && phase_busy;
  assign out_rd      = bus.slave_read && (space == SP_OUT);

  assign status = {output_done, fifo_to_arr_done, mem_to_fifo_done, 1'b0,
                   timeout_q, err_q, done_q, state_q, (state_q != S_IDLE)};

  // Next-state logic; a RESET command overrides any phase exit decided in the same cycle.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    cnt_restart = 1'b0;
    cmd_go      = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      S_RST: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = S_IDLE;
      end
      S_FILL: begin
        if (mem_to_fifo_done) begin
          if (run_q) state_d = S_DRAIN;
          else begin
            state_d  = S_IDLE;
            set_done = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      S_DRAIN: begin
        if (fifo_to_arr_done) begin
          if (run_q) state_d = S_MULT;
          else begin
            state_d  = S_IDLE;
            set_done = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      S_MULT: begin
        if (output_done) begin
          state_d  = S_IDLE;
          set_done = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          set_timeout = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_wr) begin
      if (opcode == OP_RESET) begin
        state_d     = S_RST;
        cnt_restart = 1'b1;
        set_done    = 1'b0;
        set_timeout = 1'b0;
      end else if ((opcode == OP_FILL) || (opcode == OP_DRAIN) ||
                   (opcode == OP_MULT) || (opcode == OP_RUN)) begin
        if (state_q == S_IDLE) begin
          cmd_go = 1'b1;
          case (opcode)
            OP_FILL:  state_d = S_FILL;
            OP_DRAIN: state_d = S_DRAIN;
            OP_MULT:  state_d = S_MULT;
            default: begin
              state_d = S_FILL;
              run_d   = 1'b1;
            end
          endcase
        end else begin
          set_err = 1'b1;
        end
      end else begin
        set_err = 1'b1;
      end
    end

    if ((state_d == S_IDLE) || (state_d == S_RST)) run_d = 1'b0;
    if (mem_wr_drop || set_timeout) set_err = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      if ((state_d != state_q) || cnt_restart) cnt_q <= '0;
      else if (cnt_q != CNT_W'(CNT_MAX)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as its write-1-to-clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      in_base_q  <= '0;
      w_base_q   <= '0;
      out_base_q <= '0;
    end else begin
      done_q    <= (done_q & ~w1c[0]) | set_done;
      err_q     <= (err_q & ~w1c[1]) | set_err;
      timeout_q <= (timeout_q & ~w1c[2]) | set_timeout;
      if (ctrl_wr && (row == MEM_ADDR_WIDTH'(1))) irq_en_q <= bus.slave_writedata[0];
      if (cmd_go) begin
        case (opcode)
          OP_FILL: w_base_q <= MEM_ADDR_WIDTH'(bus.slave_writedata[11:4]);
          OP_MULT: begin
            in_base_q  <= MEM_ADDR_WIDTH'(bus.slave_writedata[11:4]);
            out_base_q <= MEM_ADDR_WIDTH'(bus.slave_writedata[19:12]);
          end
          OP_RUN: begin
            w_base_q   <= MEM_ADDR_WIDTH'(bus.slave_writedata[11:4]);
            in_base_q  <= MEM_ADDR_WIDTH'(bus.slave_writedata[19:12]);
            out_base_q <= MEM_ADDR_WIDTH'(bus.slave_writedata[27:20]);
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [TPU_W-1:0] merge_beat(
    input logic [TPU_W-1:0]       row_buf,
    input logic [BEAT_IDX_W-1:0]  b,
    input logic [BUS_WIDTH-1:0]   data,
    input logic [BUS_WIDTH/8-1:0] be
  );
    logic [TPU_W-1:0] r;
    r = row_buf;
    for (int i = 0; i < BUS_WIDTH / 8; i++) begin
      if (be[i]) r[int'(b) * BUS_WIDTH + i * 8 +: 8] = data[i * 8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_mux = '0;
    case (space)
      SP_CTRL: begin
        if (row == MEM_ADDR_WIDTH'(1)) rd_mux[0] = irq_en_q;
        else if (row == MEM_ADDR_WIDTH'(2)) rd_mux[10:0] = status;
      end
      SP_IN:   rd_mux = in_buf_q[int'(beat) * BUS_WIDTH +: BUS_WIDTH];
      SP_W:    rd_mux = w_buf_q[int'(beat) * BUS_WIDTH +: BUS_WIDTH];
      default: rd_mux = '0;
    endcase
  end

  // Row buffers persist after a commit so a later partial update only touches enabled bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_buf_q     <= '0;
      w_buf_q      <= '0;
      in_commit_q  <= 1'b0;
      w_commit_q   <= 1'b0;
      in_row_q     <= '0;
      w_row_q      <= '0;
      rvalid_q     <= 1'b0;
      out_rvalid_q <= 1'b0;
      out_beat_q   <= '0;
      rdata_q      <= '0;
    end else begin
      in_commit_q <= in_wr_ok && last_beat;
      w_commit_q  <= w_wr_ok && last_beat;
      if (in_wr_ok) begin
        in_buf_q <= merge_beat(in_buf_q, beat, bus.slave_writedata, bus.slave_byteenable);
        if (last_beat) in_row_q <= row;
      end
      if (w_wr_ok) begin
        w_buf_q <= merge_beat(w_buf_q, beat, bus.slave_writedata, bus.slave_byteenable);
        if (last_beat) w_row_q <= row;
      end
      rvalid_q     <= bus.slave_read && (space != SP_OUT);
      out_rvalid_q <= out_rd;
      if (out_rd) out_beat_q <= beat;
      if (bus.slave_read && (space != SP_OUT)) rdata_q <= rd_mux;
    end
  end

  // Output-memory data arrives a cycle after rd_en, so that slice bypasses the read register.
  assign bus.slave_readdata      = out_rvalid_q ? outputMem_rd_data[int'(out_beat_q) * BUS_WIDTH +: BUS_WIDTH]
                                                : rdata_q;
  assign bus.slave_readdatavalid = rvalid_q | out_rvalid_q;

  assign irq        = done_q & irq_en_q;
  assign tpu_reset  = (state_q == S_RST);
  assign fill_fifo  = (state_q == S_FILL);
  assign drain_fifo = (state_q == S_DRAIN);
  assign tpu_active = (state_q == S_MULT);
  assign dbg_state  = state_q;

  assign inputMem_wr_en    = {WIDTH_HEIGHT{in_commit_q}};
  assign inputMem_wr_addr  = {WIDTH_HEIGHT{in_row_q}};
  assign inputMem_wr_data  = in_buf_q;
  assign weightMem_wr_en   = {WIDTH_HEIGHT{w_commit_q}};
  assign weightMem_wr_addr = {WIDTH_HEIGHT{w_row_q}};
  assign weightMem_wr_data = w_buf_q;

  assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{in_base_q}};
  assign weightMem_rd_addr_base = {WIDTH_HEIGHT{w_base_q}};
  assign outputMem_wr_addr_base = {WIDTH_HEIGHT{out_base_q}};

  assign outputMem_rd_en   = {WIDTH_HEIGHT{out_rd}};
  assign outputMem_rd_addr = out_rd ? {WIDTH_HEIGHT{row}} : '0;

endmodule

// File: tb/tb_tpu_avalon_sequencer.sv
// Directed bench for tpu_avalon_sequencer: expected read data and row writes are queued at
// issue time and checked by a monitor when the DUT presents them.
module tb_tpu_avalon_sequencer;
  localparam int BW    = 64;
  localparam int WH    = 16;
  localparam int MAW   = 8;
  localparam int TPU_W = WH * 8;
  localparam int AW    = 11;
  localparam int REC_W = 1 + MAW + TPU_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tpu_avalon_sequencer_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  logic              irq, tpu_reset, tpu_active, fill_fifo, drain_fifo;
  logic [WH-1:0]     inputMem_wr_en, weightMem_wr_en, outputMem_rd_en;
  logic [WH*MAW-1:0] inputMem_wr_addr, weightMem_wr_addr, outputMem_rd_addr;
  logic [WH*MAW-1:0] inputMem_rd_addr_base, weightMem_rd_addr_base, outputMem_wr_addr_base;
  logic [TPU_W-1:0]  inputMem_wr_data, weightMem_wr_data;
  logic [TPU_W-1:0]  outputMem_rd_data = '0;
  logic              mem_to_fifo_done = 1'b0, fifo_to_arr_done = 1'b0, output_done = 1'b0;
  logic [2:0]        dbg_state;

  tpu_avalon_sequencer #(
    .BUS_WIDTH(BW), .WIDTH_HEIGHT(WH), .MEM_ADDR_WIDTH(MAW),
    .RESET_CYCLES(4), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq),
    .tpu_reset(tpu_reset), .tpu_active(tpu_active), .fill_fifo(fill_fifo), .drain_fifo(drain_fifo),
    .inputMem_wr_en(inputMem_wr_en), .inputMem_wr_addr(inputMem_wr_addr), .inputMem_wr_data(inputMem_wr_data),
    .weightMem_wr_en(weightMem_wr_en), .weightMem_wr_addr(weightMem_wr_addr), .weightMem_wr_data(weightMem_wr_data),
    .inputMem_rd_addr_base(inputMem_rd_addr_base), .weightMem_rd_addr_base(weightMem_rd_addr_base),
    .outputMem_wr_addr_base(outputMem_wr_addr_base),
    .outputMem_rd_en(outputMem_rd_en), .outputMem_rd_addr(outputMem_rd_addr), .outputMem_rd_data(outputMem_rd_data),
    .mem_to_fifo_done(mem_to_fifo_done), .fifo_to_arr_done(fifo_to_arr_done), .output_done(output_done),
    .dbg_state(dbg_state)
  );

  // Output memory stand-in: row r holds {B0..r, A0..r}, one cycle read latency.
  always @(posedge clk) begin
    if (outputMem_rd_en[0])
      outputMem_rd_data <= {8'hB0, 48'h0, outputMem_rd_addr[MAW-1:0], 8'hA0, 48'h0, outputMem_rd_addr[MAW-1:0]};
  end

  // Scoreboard
  logic [BW-1:0]    exp_q[$];
  logic [REC_W-1:0] exp_wr_q[$];
  logic [REC_W-1:0] mon_got, mon_exp;
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.slave_readdatavalid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_readdata: got %0h with nothing expected", bus.slave_readdata);
        end else begin
          chk("readdata", bus.slave_readdata, exp_q.pop_front());
        end
      end
      if ((|inputMem_wr_en) || (|weightMem_wr_en)) begin
        mon_got = (|weightMem_wr_en) ? {1'b1, weightMem_wr_addr[MAW-1:0], weightMem_wr_data}
                                     : {1'b0, inputMem_wr_addr[MAW-1:0], inputMem_wr_data};
        if (exp_wr_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_row_write: got %0h with nothing expected", mon_got);
        end else begin
          mon_exp = exp_wr_q.pop_front();
          chk("row_write", mon_got, mon_exp);
          chk("row_wr_en_all", (|weightMem_wr_en) ? weightMem_wr_en : inputMem_wr_en, {WH{1'b1}});
          chk("row_wr_addr_repl", (|weightMem_wr_en) ? weightMem_wr_addr : inputMem_wr_addr,
              {WH{mon_exp[TPU_W +: MAW]}});
        end
      end
    end
  end

  // Driver tasks: entered and left 1 time unit after a rising edge.
  function automatic logic [AW-1:0] mk_addr(input logic [1:0] sp, input logic [7:0] r, input logic b);
    return {sp, r, b};
  endfunction

  task automatic bus_write(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [7:0] be);
    bus.slave_address    = a;
    bus.slave_writedata  = d;
    bus.slave_byteenable = be;
    bus.slave_write      = 1'b1;
    @(posedge clk); #1;
    bus.slave_write      = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [BW-1:0] exp);
    exp_q.push_back(exp);
    bus.slave_address = a;
    bus.slave_read    = 1'b1;
    @(posedge clk); #1;
    bus.slave_read    = 1'b0;
    @(negedge clk);
    chk("readdatavalid_next_cycle", bus.slave_readdatavalid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // controls = {tpu_reset, fill_fifo, drain_fifo, tpu_active}
  task automatic sample_phase(input string name, input logic [2:0] st, input logic [3:0] controls);
    @(negedge clk);
    chk({name, "_state"}, dbg_state, st);
    chk({name, "_controls"}, {tpu_reset, fill_fifo, drain_fifo, tpu_active}, controls);
    @(posedge clk); #1;
  endtask

  task automatic pulse_done(input int which);
    case (which)
      0: mem_to_fifo_done = 1'b1;
      1: fifo_to_arr_done = 1'b1;
      default: output_done = 1'b1;
    endcase
    @(posedge clk); #1;
    mem_to_fifo_done = 1'b0;
    fifo_to_arr_done = 1'b0;
    output_done      = 1'b0;
  endtask

  localparam logic [AW-1:0] A_CMD    = {2'b00, 8'd0, 1'b0};
  localparam logic [AW-1:0] A_IRQEN  = {2'b00, 8'd1, 1'b0};
  localparam logic [AW-1:0] A_STATUS = {2'b00, 8'd2, 1'b0};

  int rst_hi;
  int fill_cycles;

  initial begin
    bus.slave_address    = '0;
    bus.slave_read       = 1'b0;
    bus.slave_write      = 1'b0;
    bus.slave_writedata  = '0;
    bus.slave_byteenable = '0;

    // Reset state
    @(negedge clk);
    chk("reset_controls", {tpu_reset, fill_fifo, drain_fifo, tpu_active}, 4'b0000);
    chk("reset_irq", irq, 1'b0);
    chk("reset_rvalid", bus.slave_readdatavalid, 1'b0);
    chk("reset_readdata", bus.slave_readdata, 64'h0);
    chk("reset_wr_en", {inputMem_wr_en, weightMem_wr_en}, 32'h0);
    chk("reset_state", dbg_state, 3'd0);
    chk("reset_bases", {inputMem_rd_addr_base, weightMem_rd_addr_base, outputMem_wr_addr_base}, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    bus_read(A_STATUS, 64'h0);

    // RESET command: tpu_reset for exactly 4 cycles, state 1 then 0, no done
    bus_write(A_CMD, 64'hF, 8'hFF);
    rst_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) chk("rst_cmd_state1", dbg_state, 3'd1);
      if (tpu_reset) rst_hi++;
    end
    chk("rst_pulse_cycles", rst_hi, 4);
    chk("rst_back_idle", dbg_state, 3'd0);
    @(posedge clk); #1;
    bus_read(A_STATUS, 64'h0);

    // Input row 5, two full beats
    exp_wr_q.push_back({1'b0, 8'd5, 128'h2222222222222222_1111111111111111});
    bus_write(mk_addr(2'b01, 8'd5, 1'b0), 64'h1111111111111111, 8'hFF);
    bus_write(mk_addr(2'b01, 8'd5, 1'b1), 64'h2222222222222222, 8'hFF);
    idle(2);

    // Partial beat 0 then empty-enable beat 1 to commit
    exp_wr_q.push_back({1'b0, 8'd5, 128'h2222222222222222_11111111AAAAAAAA});
    bus_write(mk_addr(2'b01, 8'd5, 1'b0), 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    bus_write(mk_addr(2'b01, 8'd5, 1'b1), 64'hFFFFFFFFFFFFFFFF, 8'h00);
    idle(2);
    bus_read(mk_addr(2'b01, 8'd0, 1'b0), 64'h11111111AAAAAAAA);

    // Weight row 9
    exp_wr_q.push_back({1'b1, 8'd9, 128'hFEDCBA9876543210_0123456789ABCDEF});
    bus_write(mk_addr(2'b10, 8'd9, 1'b0), 64'h0123456789ABCDEF, 8'hFF);
    bus_write(mk_addr(2'b10, 8'd9, 1'b1), 64'hFEDCBA9876543210, 8'hFF);
    idle(2);

    // Full RUN w=2 in=3 out=7 with irq enabled
    bus_write(A_IRQEN, 64'h1, 8'hFF);
    bus_read(A_IRQEN, 64'h1);
    bus_write(A_CMD, 64'h0070_3024, 8'hFF);
    sample_phase("run_fill", 3'd2, 4'b0100);
    chk("run_w_base", weightMem_rd_addr_base, {WH{8'h02}});
    chk("run_in_base", inputMem_rd_addr_base, {WH{8'h03}});
    chk("run_out_base", outputMem_wr_addr_base, {WH{8'h07}});
    idle(8);
    pulse_done(0);
    sample_phase("run_drain", 3'd3, 4'b0010);
    idle(9);
    pulse_done(1);
    sample_phase("run_mult", 3'd4, 4'b0001);
    idle(9);
    pulse_done(2);
    sample_phase("run_end", 3'd0, 4'b0000);
    chk("run_irq", irq, 1'b1);
    bus_read(A_STATUS, 64'h10);
    bus_write(A_STATUS, 64'h10, 8'hFF);
    chk("w1c_done_irq", irq, 1'b0);
    bus_read(A_STATUS, 64'h0);

    // FILL with no done: watchdog after 4096 cycles
    bus_write(A_CMD, 64'h41, 8'hFF);
    fill_cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!fill_fifo) break;
      fill_cycles++;
    end
    chk("watchdog_cycles", fill_cycles, 4096);
    @(posedge clk); #1;
    chk("fill_w_base", weightMem_rd_addr_base, {WH{8'h04}});
    bus_read(A_STATUS, 64'h60);
    bus_write(A_STATUS, 64'h60, 8'hFF);
    bus_read(A_STATUS, 64'h0);

    // Unknown opcode
    bus_write(A_CMD, 64'h5, 8'hFF);
    bus_read(A_STATUS, 64'h20);
    bus_write(A_STATUS, 64'h20, 8'hFF);

    // MULT in=0x0A out=0x0B; busy command, dropped mem write, output reads
    bus_write(A_CMD, 64'hB0A3, 8'hFF);
    sample_phase("mult", 3'd4, 4'b0001);
    chk("mult_in_base", inputMem_rd_addr_base, {WH{8'h0A}});
    chk("mult_out_base", outputMem_wr_addr_base, {WH{8'h0B}});
    bus_write(A_CMD, 64'h2, 8'hFF);
    sample_phase("mult_busy_cmd", 3'd4, 4'b0001);
    bus_write(mk_addr(2'b01, 8'd1, 1'b1), 64'h5555555555555555, 8'hFF);
    idle(2);
    bus_read(A_STATUS, 64'h29);
    bus_read(mk_addr(2'b01, 8'd1, 1'b1), 64'h2222222222222222);
    bus_read(mk_addr(2'b11, 8'd7, 1'b1), 64'hB000000000000007);
    bus_read(mk_addr(2'b11, 8'd7, 1'b0), 64'hA000000000000007);
    bus_write(A_STATUS, 64'h20, 8'hFF);
    bus_write(A_CMD, 64'hF, 8'hFF);
    sample_phase("abort_rst", 3'd1, 4'b1000);
    idle(6);
    bus_read(A_STATUS, 64'h0);

    // Async reset in the middle of FILL
    bus_write(A_CMD, 64'h1, 8'hFF);
    sample_phase("pre_async_fill", 3'd2, 4'b0100);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_fill", fill_fifo, 1'b0);
    chk("async_reset_state", dbg_state, 3'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    idle(1);
    bus_read(A_IRQEN, 64'h0);

    idle(3);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_wr_q_drained", exp_wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
